// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// helper used to size its saturating counters.
package reset_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    // Width of a counter that must hold values 0..max_val (at least 1 bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Two-flop synchroniser for the per-stage ready inputs. Both flop ranks are
// cleared by the synchronous Reset so no stale ready survives a reset.
module reset_sequencer_sync #(
    parameter int WIDTH = 4
) (
    input  logic             ipClk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] ready_i,
    output logic [WIDTH-1:0] ready_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-rank capture of the asynchronous ready bits
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ready_i;
            sync_q <= meta_q;
        end
    end

    assign ready_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES domain resets one at a time, each
// after the previous stage has held ready for STABLE_CYCLES. Ready timeouts
// back off and retry up to MAX_RETRIES times before a sticky fault; a ready
// dropout of an already-up stage re-sequences from that stage.
// Build option: define RESET_SEQUENCER_READY_SYNC_EN to pass ipReady through
// a 2-flop synchroniser (adds 2 cycles to every ready-related latency).
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES       = 4,
    parameter int STABLE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES   = 50000,
    parameter int RETRY_GAP_CYCLES = 64,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                              ipClk,
    input  logic                              Reset,
    input  logic [NUM_STAGES-1:0]             ipReady,
    output logic [NUM_STAGES-1:0]             opReset,
    output logic [$clog2(NUM_STAGES+1)-1:0]   opStage,
    output logic                              opDone,
    output logic                              opRetry,
    output logic                              opFault
);

    localparam int STW = $clog2(NUM_STAGES + 1);
    localparam int SCW = cnt_width(STABLE_CYCLES);
    localparam int TCW = cnt_width(TIMEOUT_CYCLES);
    localparam int GCW = cnt_width(RETRY_GAP_CYCLES);
    localparam int RCW = cnt_width(MAX_RETRIES);

    localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);
    localparam logic [TCW-1:0] TMO_MAX    = TCW'(TIMEOUT_CYCLES);
    localparam logic [GCW-1:0] GAP_LAST   = GCW'(RETRY_GAP_CYCLES - 1);
    localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRIES);
    localparam logic [STW-1:0] LAST_STAGE = STW'(NUM_STAGES - 1);
    localparam logic [STW-1:0] ALL_STAGES = STW'(NUM_STAGES);

    logic [NUM_STAGES-1:0] rdy;

`ifdef RESET_SEQUENCER_READY_SYNC_EN
    reset_sequencer_sync #(
        .WIDTH (NUM_STAGES)
    ) u_sync (
        .ipClk   (ipClk),
        .Reset   (Reset),
        .ready_i (ipReady),
        .ready_o (rdy)
    );
`else
    assign rdy = ipReady;
`endif

    state_e                state_q,   state_d;
    logic [STW-1:0]        stage_q,   stage_d;
    logic [SCW-1:0]        stable_q,  stable_d;
    logic [TCW-1:0]        tmo_q,     tmo_d;
    logic [GCW-1:0]        gap_q,     gap_d;
    logic [RCW-1:0]        retry_q,   retry_d;
    logic                  redo_q,    redo_d;
    logic [NUM_STAGES-1:0] dom_rst_q, dom_rst_d;
    logic                  done_q,    done_d;
    logic                  pulse_q,   pulse_d;
    logic                  fault_q,   fault_d;

    logic                  cur_rdy;
    logic                  drop_hit;
    logic [STW-1:0]        drop_idx;
    logic [NUM_STAGES-1:0] cur_mask;
    logic [NUM_STAGES-1:0] next_mask;
    logic [NUM_STAGES-1:0] hi_mask;

    // Decode the current/next stage bits and find the lowest up stage whose ready dropped
    always_comb begin
        cur_rdy   = 1'b0;
        drop_hit  = 1'b0;
        drop_idx  = '0;
        cur_mask  = '0;
        next_mask = '0;
        hi_mask   = '0;
        // Scan high to low so the last hit is the lowest affected stage
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (STW'(k) == stage_q) begin
                cur_rdy     = rdy[k];
                cur_mask[k] = 1'b1;
            end
            if (STW'(k) == stage_q + STW'(1)) begin
                next_mask[k] = 1'b1;
            end
            if (((state_q == ST_RUN) || ((state_q == ST_WAIT) && (STW'(k) < stage_q))) && !rdy[k]) begin
                drop_hit = 1'b1;
                drop_idx = STW'(k);
            end
        end
        for (int k = 0; k < NUM_STAGES; k++) begin
            hi_mask[k] = (STW'(k) >= drop_idx);
        end
    end

    // Sequencer next-state: dropout beats timeout beats stable-complete
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        retry_d   = retry_q;
        redo_d    = redo_q;
        dom_rst_d = dom_rst_q;
        done_d    = done_q;
        pulse_d   = 1'b0;
        fault_d   = fault_q;
        case (state_q)
            ST_HOLD: begin
                state_d      = ST_WAIT;
                stage_d      = '0;
                stable_d     = '0;
                tmo_d        = '0;
                redo_d       = 1'b0;
                dom_rst_d    = '1;
                dom_rst_d[0] = 1'b0;
            end
            ST_WAIT: begin
                if (drop_hit) begin
                    // Re-assert from the dropped stage upward; release it again next edge
                    stage_d   = drop_idx;
                    dom_rst_d = dom_rst_q | hi_mask;
                    redo_d    = 1'b1;
                    stable_d  = '0;
                    tmo_d     = '0;
                end else if (redo_q) begin
                    dom_rst_d = dom_rst_q & ~cur_mask;
                    redo_d    = 1'b0;
                    stable_d  = '0;
                    tmo_d     = '0;
                end else if (tmo_q == TMO_MAX) begin
                    dom_rst_d = '1;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RCW'(1);
                        pulse_d = 1'b1;
                        gap_d   = '0;
                        state_d = ST_BACKOFF;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else if (stable_q == STABLE_MAX) begin
                    stable_d = '0;
                    tmo_d    = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_RUN;
                        stage_d = ALL_STAGES;
                        done_d  = 1'b1;
                        retry_d = '0;
                    end else begin
                        stage_d   = stage_q + STW'(1);
                        dom_rst_d = dom_rst_q & ~next_mask;
                    end
                end else begin
                    // Neither counter is at its limit here, so the increments cannot wrap
                    tmo_d    = tmo_q + TCW'(1);
                    stable_d = cur_rdy ? (stable_q + SCW'(1)) : '0;
                end
            end
            ST_RUN: begin
                if (drop_hit) begin
                    state_d   = ST_WAIT;
                    stage_d   = drop_idx;
                    dom_rst_d = hi_mask;
                    done_d    = 1'b0;
                    redo_d    = 1'b1;
                    stable_d  = '0;
                    tmo_d     = '0;
                end
            end
            ST_BACKOFF: begin
                if (gap_q == GAP_LAST) begin
                    state_d      = ST_WAIT;
                    stage_d      = '0;
                    stable_d     = '0;
                    tmo_d        = '0;
                    redo_d       = 1'b0;
                    dom_rst_d[0] = 1'b0;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // State and output registers; Reset returns everything to the held state
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            state_q   <= ST_HOLD;
            stage_q   <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            retry_q   <= '0;
            redo_q    <= 1'b0;
            dom_rst_q <= '1;
            done_q    <= 1'b0;
            pulse_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            retry_q   <= retry_d;
            redo_q    <= redo_d;
            dom_rst_q <= dom_rst_d;
            done_q    <= done_d;
            pulse_q   <= pulse_d;
            fault_q   <= fault_d;
        end
    end

    assign opReset = dom_rst_q;
    assign opStage = stage_q;
    assign opDone  = done_q;
    assign opRetry = pulse_q;
    assign opFault = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer (3 stages, stable 4, timeout 100, gap 8,
// 2 retries). Honours RESET_SEQUENCER_READY_SYNC_EN for the ready latency.
module tb_reset_sequencer;

    localparam int N = 3;
    localparam int S = 4;
    localparam int T = 100;
    localparam int G = 8;
    localparam int R = 2;
`ifdef RESET_SEQUENCER_READY_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam int P = 5 + L;

    logic       ipClk;
    logic       Reset;
    logic [2:0] ipReady;
    logic [2:0] opReset;
    logic [1:0] opStage;
    logic       opDone;
    logic       opRetry;
    logic       opFault;

    reset_sequencer #(
        .NUM_STAGES       (N),
        .STABLE_CYCLES    (S),
        .TIMEOUT_CYCLES   (T),
        .RETRY_GAP_CYCLES (G),
        .MAX_RETRIES      (R)
    ) dut (
        .ipClk   (ipClk),
        .Reset   (Reset),
        .ipReady (ipReady),
        .opReset (opReset),
        .opStage (opStage),
        .opDone  (opDone),
        .opRetry (opRetry),
        .opFault (opFault)
    );

    initial ipClk = 1'b0;
    always #5 ipClk = ~ipClk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulse = 0;

    // Reference model: phase, stage under wait, cycles since release, ready streak
    typedef enum {M_HOLD, M_WAIT, M_RUN, M_BACK, M_FAULT} mph_e;
    mph_e       m_ph = M_HOLD;
    int         m_cur = 0, m_since = 0, m_streak = 0, m_retries = 0, m_gap = 0;
    bit         m_redo = 1'b0, m_pulse = 1'b0;
    logic [2:0] m_hist[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    endtask

    // Expected {opReset, opStage, opDone, opRetry, opFault}
    function automatic logic [7:0] m_out();
        logic [2:0] r;
        int         st;
        r  = 3'b111;
        st = m_cur;
        case (m_ph)
            M_HOLD: st = 0;
            M_WAIT: for (int j = 0; j < N; j++) r[j] = (j > m_cur) || (j == m_cur && m_redo);
            M_RUN: begin r = 3'b000; st = N; end
            default: ;
        endcase
        return {r, 2'(st), m_ph == M_RUN, m_pulse, m_ph == M_FAULT};
    endfunction

    task automatic model_step(input bit rst, input logic [2:0] in);
        logic [2:0] eff;
        int         low;
        if (L == 0) eff = in;
        else begin
            eff = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(in);
            if (rst) foreach (m_hist[i]) m_hist[i] = 3'b000;
        end
        m_pulse = 1'b0;
        low = -1;
        for (int j = N - 1; j >= 0; j--)
            if (!eff[j] && (m_ph == M_RUN || (m_ph == M_WAIT && j < m_cur))) low = j;
        if (rst) begin
            m_ph = M_HOLD; m_cur = 0; m_since = 0; m_streak = 0;
            m_retries = 0; m_gap = 0; m_redo = 1'b0;
        end else begin
            case (m_ph)
                M_HOLD: begin
                    m_ph = M_WAIT; m_cur = 0; m_since = 0; m_streak = 0; m_redo = 1'b0;
                end
                M_WAIT: begin
                    if (low >= 0) begin
                        m_cur = low; m_redo = 1'b1; m_since = 0; m_streak = 0;
                    end else if (m_redo) begin
                        m_redo = 1'b0; m_since = 0; m_streak = 0;
                    end else if (m_since >= T) begin
                        if (m_retries < R) begin
                            m_retries++; m_pulse = 1'b1; m_ph = M_BACK; m_gap = 0;
                        end else m_ph = M_FAULT;
                    end else if (m_streak >= S) begin
                        m_since = 0; m_streak = 0;
                        if (m_cur < N - 1) m_cur++;
                        else begin m_ph = M_RUN; m_retries = 0; end
                    end else begin
                        m_since++;
                        m_streak = eff[m_cur] ? m_streak + 1 : 0;
                    end
                end
                M_RUN: begin
                    if (low >= 0) begin
                        m_ph = M_WAIT; m_cur = low; m_redo = 1'b1; m_since = 0; m_streak = 0;
                    end
                end
                M_BACK: begin
                    m_gap++;
                    if (m_gap == G) begin
                        m_ph = M_WAIT; m_cur = 0; m_since = 0; m_streak = 0; m_redo = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input bit rst, input logic [2:0] rdy);
        Reset   = rst;
        ipReady = rdy;
        @(posedge ipClk);
        model_step(rst, rdy);
        #1;
        chk("cycle", {opReset, opStage, opDone, opRetry, opFault}, m_out());
        if (opRetry) n_pulse++;
    endtask

    // Ready follows each released reset, as a responsive downstream domain would
    task automatic tick_follow();
        logic [7:0] e;
        e = m_out();
        tick(1'b0, ~e[7:5]);
    endtask

    task automatic run_until(input mph_e ph, input logic [2:0] rdy, input int budget, input string nm);
        int c;
        c = 0;
        while (m_ph != ph && c < budget) begin
            tick(1'b0, rdy);
            c++;
        end
        n_chk++;
        if (m_ph == ph) n_pass++;
        else $display("FAIL %s: budget of %0d cycles expired", nm, budget);
    endtask

    typedef struct {
        bit         rst;
        bit         follow;
        logic [2:0] rdy;
        int         cyc;
        logic [2:0] e_reset;
        logic [1:0] e_stage;
        bit         e_done;
        bit         e_fault;
    } vec_t;

    vec_t tbl[9];

    initial begin
        Reset   = 1'b1;
        ipReady = 3'b000;
        for (int i = 0; i < L; i++) m_hist.push_back(3'b000);

        tbl[0] = '{1'b1, 1'b0, 3'b111, 10,    3'b111, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 3'b000, 1,     3'b110, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 3'b000, P - 1, 3'b110, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 3'b000, 1,     3'b100, 2'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 3'b000, P - 1, 3'b100, 2'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'b000, 1,     3'b000, 2'd2, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3'b000, P - 1, 3'b000, 2'd2, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 3'b000, 1,     3'b000, 2'd3, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 3'b000, 5,     3'b000, 2'd3, 1'b1, 1'b0};

        // Power-up sequence: one stage released per stable interval
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < tbl[i].cyc; c++) begin
                if (tbl[i].follow) tick_follow();
                else tick(tbl[i].rst, tbl[i].rdy);
            end
            chk($sformatf("vec%0d_reset", i), 8'(opReset), 8'(tbl[i].e_reset));
            chk($sformatf("vec%0d_stage", i), 8'(opStage), 8'(tbl[i].e_stage));
            chk($sformatf("vec%0d_done", i),  8'(opDone),  8'(tbl[i].e_done));
            chk($sformatf("vec%0d_fault", i), 8'(opFault), 8'(tbl[i].e_fault));
        end

        // One-cycle dropout of stage 1 while running
        n_pulse = 0;
        tick(1'b0, 3'b101);
        repeat (L) tick(1'b0, 3'b111);
        chk("drop_reset", 8'(opReset), 8'(3'b110));
        chk("drop_done",  8'(opDone),  8'd0);
        chk("drop_stage", 8'(opStage), 8'd1);
        tick(1'b0, 3'b111);
        chk("rerelease_reset", 8'(opReset), 8'(3'b100));
        chk("rerelease_stage", 8'(opStage), 8'd1);
        repeat (12) tick(1'b0, 3'b111);
        chk("drop_rerun_done", 8'(opDone), 8'd1);
        chk("drop_no_retry", 8'(n_pulse), 8'd0);

        // Stage 1 never ready: two retries then sticky fault
        repeat (3) tick(1'b1, 3'b101);
        n_pulse = 0;
        run_until(M_FAULT, 3'b101, 800, "reach_fault");
        chk("fault_flag",    8'(opFault), 8'd1);
        chk("fault_retries", 8'(n_pulse), 8'd2);
        chk("fault_reset",   8'(opReset), 8'(3'b111));
        repeat (20) tick(1'b0, 3'b111);
        chk("fault_sticky",  8'(opFault), 8'd1);

        // Stage 2 ready toggling every 3 cycles never becomes stable
        repeat (3) tick(1'b1, 3'b111);
        n_pulse = 0;
        for (int c = 0; c < 160; c++) tick(1'b0, {((c / 3) % 2) == 0, 2'b11});
        chk("toggle_one_timeout", 8'(n_pulse), 8'd1);

        // Reset during backoff clears the retry count
        repeat (3) tick(1'b1, 3'b101);
        run_until(M_BACK, 3'b101, 400, "reach_backoff");
        repeat (3) tick(1'b0, 3'b101);
        tick(1'b1, 3'b101);
        chk("rst_back_out", {opReset, opStage, opDone, opRetry, opFault}, 8'b111_00_000);
        n_pulse = 0;
        run_until(M_FAULT, 3'b101, 800, "reach_fault2");
        chk("fault2_retries", 8'(n_pulse), 8'd2);
        // Reset during fault
        tick(1'b1, 3'b101);
        chk("rst_fault_out", {opReset, opStage, opDone, opRetry, opFault}, 8'b111_00_000);

        // Randomised ready activity with occasional dead stages and resets
        begin
            logic [2:0] dead;
            logic [2:0] rdy;
            bit         rst;
            dead = 3'b000;
            for (int c = 0; c < 4000; c++) begin
                if (c % 500 == 0) dead = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
                if (c % 500 == 200) dead = 3'b000;
                rdy = 3'b111 & ~dead;
                for (int b = 0; b < N; b++) if ($urandom_range(0, 29) == 0) rdy[b] = 1'b0;
                rst = (c < 2) || ($urandom_range(0, 299) == 0);
                tick(rst, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Downstream consumer of the delayed power-on reset.
- Releases NUM_STAGES domain resets (PLLs, memory controllers, transceivers, user logic) one at a time.
- Each stage is released only after the previous stage reports ready and stays ready for a debounce interval.
- Handles ready timeouts with bounded retry, dropout re-sequencing, and a sticky fault.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs (1..16).
- STABLE_CYCLES, 16: consecutive ready-high cycles required before a stage counts as up (>=1).
- TIMEOUT_CYCLES, 50000: cycles allowed from a stage's release until it counts as up (>STABLE_CYCLES).
- RETRY_GAP_CYCLES, 64: cycles all resets are held asserted between retry attempts (>=1).
- MAX_RETRIES, 3: retries allowed before the sticky fault; 0 means the first timeout faults.

Ports:
- ipClk  in  1  clock
- Reset  in  1  synchronous, active-high reset (delayed reset output of the upstream stage)
- ipReady  in  NUM_STAGES  per-stage ready/lock; bit k belongs to stage k
- opReset  out  NUM_STAGES  per-stage reset, active-high; bit k drives stage k
- opStage  out  $clog2(NUM_STAGES+1)  index of the stage being waited on; NUM_STAGES when done
- opDone  out  1  all stages up and stable
- opRetry  out  1  one-cycle pulse on each timeout that leads to a retry
- opFault  out  1  sticky: retries exhausted

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock ipClk.
- All outputs are registered.
- While Reset=1:
  - opReset = all ones; opStage = 0; opDone = 0; opRetry = 0; opFault = 0.
  - State = HOLD; all counters and the retry count are cleared.
- States: HOLD, WAIT, RUN, BACKOFF, FAULT.
- HOLD -> WAIT on the first edge with Reset=0. On that edge opReset[0] becomes 0 and the timeout and stable counters clear.
- WAIT, stage k:
  - Stable counter increments while rdy[k]=1 and clears to 0 when rdy[k]=0.
  - Timeout counter increments every cycle.
  - On the edge where the stable counter reaches STABLE_CYCLES:
    - if k < NUM_STAGES-1: opReset[k+1] becomes 0, stage = k+1, both counters clear;
    - otherwise: state becomes RUN, opDone = 1, opStage = NUM_STAGES, retry count clears.
- Timeout: in WAIT, when the timeout counter reaches TIMEOUT_CYCLES before the stage is stable:
  - if retry count < MAX_RETRIES: retry count increments, opRetry pulses, opReset = all ones, state becomes BACKOFF;
  - otherwise: state becomes FAULT, opFault = 1, opReset = all ones.
- BACKOFF: after RETRY_GAP_CYCLES cycles, goes to WAIT for stage 0 (opReset[0] = 0, opStage = 0).
- Dropout: in WAIT or RUN, rdy[j]=0 for any stage j that already counted as up (j < k in WAIT; any j in RUN):
  - opReset[NUM_STAGES-1:j] become 1 on the next edge;
  - opReset[j] is deasserted again on the following edge; stage = j; counters clear.
  - In RUN, opDone falls on the same edge opReset reasserts.
  - A dropout does not count as a retry.
- Priority: Reset > dropout of the lowest affected j > timeout > stable-complete.
- FAULT is exited only by Reset.
- rdy is ipReady, or its synchronised copy when the optional feature is compiled in.
- Counter widths: $clog2(max+1). Counters saturate and never wrap.

Optional Feature:
- Macro: RESET_SEQUENCER_READY_SYNC_EN.
- Defined: each ipReady bit passes through a 2-flop synchroniser (flops cleared to 0 by Reset). All ready-related latencies grow by 2 cycles.
- Undefined: ipReady is used directly and is assumed to already be in the ipClk domain.

Decomposition:
- Shared package reset_sequencer_pkg:
  - state enum (HOLD, WAIT, RUN, BACKOFF, FAULT);
  - counter-width helper constants.
- One sub-module, reset_sequencer_sync: a NUM_STAGES-wide 2-flop synchroniser, instantiated only under the macro.

Test Plan:
Common parameters: NUM_STAGES=3, STABLE_CYCLES=4, TIMEOUT_CYCLES=100, RETRY_GAP_CYCLES=8, MAX_RETRIES=2; macro off unless stated.
1. Reset held 10 cycles, then released; ipReady tied high -> opReset steps 111->110->100->000 at 5-cycle spacing; opDone=1 with opStage=3.
2. ipReady[1] low -> at timeout opRetry pulses and opReset=111 for 8 cycles, then stage 0 restarts; after a 3rd timeout opFault=1 and opReset=111 until Reset.
3. In RUN, drop ipReady[1] for 1 cycle -> opReset goes to 110 next edge, opDone=0, stage 1 re-released next edge; opRetry stays 0.
4. In WAIT of stage 2, ipReady[2] toggles every 3 cycles -> stable counter never reaches 4; timeout at 100 cycles.
5. Assert Reset mid-BACKOFF and mid-FAULT -> all outputs return to reset values next edge; retry count cleared.
6. Macro on, repeat scenario 1 -> each stage release delayed 2 further cycles.
